// File: rtl/fpu_issue.sv
// fpu_issue: request FIFO plus single-outstanding sequencer in front of the FPU.
// Optional WAIT watchdog: define FPU_ISSUE_TIMEOUT_EN.
module fpu_issue #(
  parameter int OP_W    = 5,
  parameter int TAG_W   = 6,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  output logic [OP_W-1:0]  fpu_op,
  output logic             fpu_ready,
  input  logic             fpu_valid,
  input  logic [31:0]      fpu_y32,
  input  logic             fpu_y1,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             wb_flag,
  output logic             wb_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  req_t             mem_q [DEPTH];
  req_t             head;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [31:0]      x1_q, x1_d;
  logic [31:0]      x2_q, x2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             flag_q, flag_d;
  logic             rdy_q, rdy_d;
  logic             issue_q, issue_d;
  logic             wbv_q, wbv_d;
  logic             busy_q, busy_d;
  logic             push, pop, empty;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int LW = $clog2(TIMEOUT + 1);
  localparam int TW = (LW < 8) ? 8 : ((LW > 32) ? 32 : LW);
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             err_q, err_d;
`else
  logic [31:0]      unused_tmo;
  assign unused_tmo = 32'(TIMEOUT);
`endif

  assign empty = (cnt_q == '0);
  assign push  = req_valid && rdy_q;
  assign head  = mem_q[rptr_q];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    tag_d   = tag_q;
    data_d  = data_q;
    flag_d  = flag_q;
    pop     = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fpu_valid) begin
          data_d  = fpu_y32;
          flag_d  = fpu_y1;
          state_d = DONE;
`ifdef FPU_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      WAIT: begin
`ifdef FPU_ISSUE_TIMEOUT_EN
        tcnt_d = tcnt_q + 1'b1;
`endif
        if (fpu_valid) begin
          data_d  = fpu_y32;
          flag_d  = fpu_y1;
          state_d = DONE;
`ifdef FPU_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tcnt_d == TW'(TIMEOUT)) begin
          // give up: quiet NaN with the error marker set
          data_d  = 32'h7FC0_0000;
          flag_d  = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (wb_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      op_d  = head.op;
      x1_d  = head.x1;
      x2_d  = head.x2;
      tag_d = head.tag;
    end

    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rdy_d   = (cnt_d != (AW+1)'(DEPTH));
    issue_d = (state_d == ISSUE);
    wbv_d   = (state_d == DONE);
    busy_d  = (cnt_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{op: req_op, x1: req_x1,
                                 x2: req_x2, tag: req_tag};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      rdy_q   <= 1'b1;
      issue_q <= 1'b0;
      wbv_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      rdy_q   <= rdy_d;
      issue_q <= issue_d;
      wbv_q   <= wbv_d;
      busy_q  <= busy_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready = rdy_q;
  assign fpu_x1    = x1_q;
  assign fpu_x2    = x2_q;
  assign fpu_op    = op_q;
  assign fpu_ready = issue_q;
  assign wb_valid  = wbv_q;
  assign wb_tag    = tag_q;
  assign wb_data   = data_q;
  assign wb_flag   = flag_q;
  assign busy      = busy_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
  assign wb_err    = err_q;
`else
  assign wb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed cases plus random traffic against a
// transaction-level model of the issue stage; the bench plays the FPU.
module tb_fpu_issue;

  localparam int DEPTH = 2;
  localparam int TMO   = 10;
  localparam logic [4:0] FADD = 5'd0;
  localparam logic [4:0] FNEG = 5'd5;
  localparam logic [4:0] FCLT = 5'd12;

  logic        clk = 0;
  logic        rstn = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [4:0]  req_op = 0;
  logic [31:0] req_x1 = 0, req_x2 = 0;
  logic [5:0]  req_tag = 0;
  logic [31:0] fpu_x1, fpu_x2;
  logic [4:0]  fpu_op;
  logic        fpu_ready;
  logic        fpu_valid = 0;
  logic [31:0] fpu_y32 = 0;
  logic        fpu_y1 = 0;
  logic        wb_valid;
  logic        wb_ready = 1;
  logic [5:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_flag, wb_err, busy;

  fpu_issue #(.OP_W(5), .TAG_W(6), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_op(fpu_op),
    .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
    .fpu_y32(fpu_y32), .fpu_y1(fpu_y1),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_flag(wb_flag), .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // bench-side FPU: fixed or random latency, optional directed result
  int          fix_lat = 0;
  int          left = 0;
  bit          pend = 0;
  bit          dir_en = 0;
  logic [31:0] dir_y = 0;
  logic        dir_f = 0;
  bit          stray_en = 0;
  bit          kick = 0;

  always @(posedge clk) begin
    #1;
    fpu_valid = 0;
    if (!rstn) begin
      pend = 0;
    end else begin
      if (fpu_ready) begin
        pend = 1;
        left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
      end
      if (pend) begin
        if (left == 0) begin
          fpu_valid = 1;
          fpu_y32 = dir_en ? dir_y : $urandom;
          fpu_y1  = dir_en ? dir_f : 1'($urandom);
          pend = 0;
        end else begin
          left--;
        end
      end else if (kick || (stray_en && $urandom_range(0, 3) == 0)) begin
        kick = 0;
        fpu_valid = 1;
        fpu_y32 = $urandom;
        fpu_y1  = 1'($urandom);
      end
    end
  end

  // transaction-level model: queue of waiting requests, the op held
  // at the FPU, and the result held for write-back
  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
  } req_t;

  req_t        m_q[$];
  req_t        m_cur;
  bit          m_out, m_iss, m_held;
  int          m_tw;
  logic [5:0]  m_tag;
  logic [31:0] m_data;
  logic        m_flag, m_err;

  always @(negedge clk) begin
    bit push, cpl, tmo, acc, ld;
    if (!rstn) begin
      m_q.delete();
      m_cur = '0; m_out = 0; m_iss = 0; m_held = 0; m_tw = 0;
      m_tag = 0; m_data = 0; m_flag = 0; m_err = 0;
    end
    chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
    chk("fpu_ready", 32'(fpu_ready), 32'(m_iss));
    chk("wb_valid", 32'(wb_valid), 32'(m_held));
    chk("busy", 32'(busy), 32'(m_q.size() > 0 || m_out || m_held));
    chk("fpu_op", 32'(fpu_op), 32'(m_cur.op));
    chk("fpu_x1", fpu_x1, m_cur.a);
    chk("fpu_x2", fpu_x2, m_cur.b);
    if (m_held || !rstn) begin
      chk("wb_tag", 32'(wb_tag), 32'(m_tag));
      chk("wb_data", wb_data, m_data);
      chk("wb_flag", 32'(wb_flag), 32'(m_flag));
      chk("wb_err", 32'(wb_err), 32'(m_err));
    end
    if (rstn) begin
      if (fpu_ready) pulses++;
      push = req_valid && (m_q.size() < DEPTH);
      cpl  = m_out && fpu_valid;
      tmo  = 0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      if (m_out && !m_iss && !fpu_valid && m_tw + 1 == TMO) tmo = 1;
`endif
      acc = m_held && wb_ready;
      ld  = (m_q.size() > 0) && ((!m_out && !m_held) || acc);
      if (m_out && !m_iss) m_tw++;
      if (cpl) begin
        m_held = 1; m_out = 0; m_tag = m_cur.tag;
        m_data = fpu_y32; m_flag = fpu_y1; m_err = 0;
      end else if (tmo) begin
        m_held = 1; m_out = 0; m_tag = m_cur.tag;
        m_data = 32'h7FC0_0000; m_flag = 0; m_err = 1;
      end
      if (acc) m_held = 0;
      if (ld) begin
        m_cur = m_q.pop_front();
        m_out = 1;
        m_tw = 0;
      end
      m_iss = ld;
      if (push) m_q.push_back('{req_op, req_x1, req_x2, req_tag});
    end
  end

  task automatic push_req(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t);
    int n = 0;
    bit ok = 0;
    req_op = op; req_x1 = a; req_x2 = b; req_tag = t; req_valid = 1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_valid && n < 100);
    if (!wb_valid) chk("wb_timeout", 0, 1);
  endtask

  task automatic wait_issue();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fpu_ready && n < 100);
    if (!fpu_ready) chk("issue_timeout", 0, 1);
  endtask

  initial begin
    int n, p0, k;
    logic [5:0] got[3];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_fpu_ready", 32'(fpu_ready), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb_data", wb_data, 0);
    @(posedge clk); #1;
    rstn = 1;

    // single FADD, FPU answers two cycles after the start pulse
    fix_lat = 2; dir_en = 1; dir_y = 32'h4040_0000; dir_f = 0;
    p0 = pulses;
    push_req(FADD, 32'h3F80_0000, 32'h4000_0000, 6'd5);
    @(negedge clk);
    chk("t1_issue_early", 32'(fpu_ready), 0);
    @(negedge clk);
    chk("t1_issue_t2", 32'(fpu_ready), 1);
    chk("t1_x1", fpu_x1, 32'h3F80_0000);
    wait_wb(n);
    chk("t1_wb_lat", n, 3);
    chk("t1_tag", 32'(wb_tag), 5);
    chk("t1_data", wb_data, 32'h4040_0000);
    chk("t1_pulses", pulses - p0, 1);
    @(posedge clk); #1;

    // FNEG completing in the ISSUE cycle
    fix_lat = 0; dir_y = 32'hBF80_0000;
    push_req(FNEG, 32'h3F80_0000, 32'h0, 6'd7);
    @(negedge clk);
    @(negedge clk);
    chk("t2_issue", 32'(fpu_ready), 1);
    wait_wb(n);
    chk("t2_wb_lat", n, 1);
    chk("t2_data", wb_data, 32'hBF80_0000);
    @(posedge clk); #1;

    // three back-to-back requests under write-back stall
    wb_ready = 0; dir_en = 0;
    p0 = pulses;
    push_req(FADD, 32'h1, 32'h2, 6'd1);
    push_req(FADD, 32'h3, 32'h4, 6'd2);
    push_req(FADD, 32'h5, 32'h6, 6'd3);
    @(negedge clk);
    chk("t3_full", 32'(req_ready), 0);
    repeat (3) @(negedge clk);
    chk("t3_stall_pulses", pulses - p0, 1);
    @(posedge clk); #1;
    wb_ready = 1;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (wb_valid && wb_ready) begin
        got[k] = wb_tag;
        k++;
      end
    end
    chk("t3_count", k, 3);
    chk("t3_tag0", 32'(got[0]), 1);
    chk("t3_tag1", 32'(got[1]), 2);
    chk("t3_tag2", 32'(got[2]), 3);
    chk("t3_pulses", pulses - p0, 3);
    @(posedge clk); #1;

    // FCLT flag held under backpressure
    wb_ready = 0; fix_lat = 1; dir_en = 1; dir_y = 0; dir_f = 1;
    push_req(FCLT, 32'hBF80_0000, 32'h0, 6'd9);
    wait_wb(n);
    chk("t4_flag", 32'(wb_flag), 1);
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(wb_valid), 1);
      chk("t4_hold_flag", 32'(wb_flag), 1);
    end
    @(posedge clk); #1;
    wb_ready = 1;
    @(posedge clk); #1;

`ifdef FPU_ISSUE_TIMEOUT_EN
    fix_lat = 1000;
    push_req(FADD, 32'h7, 32'h8, 6'd11);
    wait_issue();
    wait_wb(n);
    chk("t6_tmo_lat", n, 11);
    chk("t6_tmo_err", 32'(wb_err), 1);
    chk("t6_tmo_data", wb_data, 32'h7FC0_0000);
    chk("t6_tmo_flag", 32'(wb_flag), 0);
    @(posedge clk); #1;
    fix_lat = 10; dir_y = 32'h1234_5678; dir_f = 0;
    push_req(FADD, 32'h9, 32'hA, 6'd12);
    wait_issue();
    wait_wb(n);
    chk("t6_edge_lat", n, 11);
    chk("t6_edge_err", 32'(wb_err), 0);
    chk("t6_edge_data", wb_data, 32'h1234_5678);
    @(posedge clk); #1;
`endif

    // reset during WAIT, then a stray completion
    fix_lat = 1000;
    push_req(FADD, 32'hDEAD_BEEF, 32'h1, 6'd13);
    wait_issue();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_wb_valid", 32'(wb_valid), 0);
    chk("t5_x1", fpu_x1, 0);
    @(posedge clk); #1;
    rstn = 1;
    kick = 1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_wb", 32'(wb_valid), 0);
      chk("t5_idle", 32'(busy), 0);
    end
    @(posedge clk); #1;

    // random traffic
    dir_en = 0; fix_lat = -1; stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom);
      req_op  = 5'($urandom);
      req_x1  = $urandom;
      req_x2  = $urandom;
      req_tag = 6'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 0; wb_ready = 1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
